// File: rtl/burst_rd_ctrl.sv
// Burst read controller: issues one read strobe per beat to a slow slave with
// wait-state handshake, captures returned data and aborts on a per-beat timeout.
module burst_rd_ctrl #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int LW     = 4,
  parameter int MAX_WS = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic [AW-1:0] addr_in,
  input  logic [LW-1:0] len_in,
  input  logic          ws,
  input  logic [DW-1:0] data_in,
  output logic          rd,
  output logic [AW-1:0] addr_out,
  output logic [DW-1:0] data_out,
  output logic          data_valid,
  output logic          ds,
  output logic          err_timeout,
  output logic          busy
);

  // state | meaning
  // IDLE  | waiting for go
  // READ  | strobe issued, wait counter cleared
  // WAIT  | waiting for ws=0, counting wait states
  // DONE  | ds pulse, burst completed
  // ERR   | err_timeout pulse, burst aborted
  typedef enum logic [2:0] {IDLE, READ, WAIT, DONE, ERR} state_t;

  localparam int WCW = (MAX_WS < 1) ? 1 : $clog2(MAX_WS + 1);
  localparam logic [WCW-1:0] WS_LAST = WCW'(MAX_WS - 1);

  state_t         state;
  state_t         state_nxt;
  logic [LW-1:0]  beat_cnt;
  logic [WCW-1:0] wait_cnt;
  logic           timeout_hit;

  assign timeout_hit = (MAX_WS != 0) && (wait_cnt == WS_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (go) state_nxt = READ;
      READ: state_nxt = WAIT;
      WAIT: begin
        if (!ws) state_nxt = (beat_cnt == '0) ? DONE : READ;
        else if (timeout_hit) state_nxt = ERR;
      end
      DONE: state_nxt = IDLE;
      ERR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they match a Moore decode of state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr_out    <= '0;
      data_out    <= '0;
      beat_cnt    <= '0;
      wait_cnt    <= '0;
      rd          <= 1'b0;
      ds          <= 1'b0;
      data_valid  <= 1'b0;
      err_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      rd          <= (state_nxt == READ) || (state_nxt == WAIT);
      ds          <= (state_nxt == DONE);
      err_timeout <= (state_nxt == ERR);
      busy        <= (state_nxt != IDLE);
      data_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            addr_out <= addr_in;
            beat_cnt <= len_in;
          end
        end
        READ: wait_cnt <= '0;
        WAIT: begin
          if (!ws) begin
            data_out   <= data_in;
            data_valid <= 1'b1;
            if (beat_cnt != '0) begin
              beat_cnt <= beat_cnt - 1'b1;
              addr_out <= addr_out + 1'b1;
            end
          end else if (!timeout_hit) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_rd_ctrl.sv
// Directed bench for burst_rd_ctrl: logs outputs per cycle of each burst and
// compares selected cycles and totals against hand-computed values.
module tb_burst_rd_ctrl;
  logic       clk = 1'b0;
  logic       rst, go, ws;
  logic [7:0] addr_in, data_in;
  logic [3:0] len_in;
  logic       rd, data_valid, ds, err_timeout, busy;
  logic [7:0] addr_out, data_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] addr_log [0:63];
  logic [7:0] dout_log [0:63];
  logic       rd_log   [0:63];
  logic       dv_log   [0:63];
  logic       ds_log   [0:63];
  logic       err_log  [0:63];
  logic       busy_log [0:63];
  int rd_cnt, dv_cnt, ds_cnt, err_cnt;

  burst_rd_ctrl #(.AW(8), .DW(8), .LW(4), .MAX_WS(15)) dut (
    .clk(clk), .rst(rst), .go(go), .addr_in(addr_in), .len_in(len_in),
    .ws(ws), .data_in(data_in), .rd(rd), .addr_out(addr_out),
    .data_out(data_out), .data_valid(data_valid), .ds(ds),
    .err_timeout(err_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Starts a burst from IDLE; cycle k is the k-th cycle after the edge that samples go.
  task automatic run(input logic [7:0] a, input logic [3:0] l, input logic [63:0] wsm,
                     input logic [7:0] dbase, input int ncyc, input int go_at, input int rst_at);
    go = 1'b1; addr_in = a; len_in = l; ws = 1'b0; data_in = 8'h00;
    rd_cnt = 0; dv_cnt = 0; ds_cnt = 0; err_cnt = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      addr_log[k] = addr_out; dout_log[k] = data_out; rd_log[k] = rd;
      dv_log[k] = data_valid; ds_log[k] = ds; err_log[k] = err_timeout; busy_log[k] = busy;
      rd_cnt += int'(rd); dv_cnt += int'(data_valid);
      ds_cnt += int'(ds); err_cnt += int'(err_timeout);
      go      = (k == go_at);
      addr_in = (k == go_at) ? 8'h77 : 8'h00;
      len_in  = (k == go_at) ? 4'hF : 4'h0;
      rst     = (k == rst_at);
      ws      = wsm[k];
      data_in = 8'(dbase + 8'(k));
    end
    go = 1'b0; ws = 1'b0; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; ws = 1'b0; addr_in = 8'h00; len_in = 4'h0; data_in = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_rd", {31'd0, rd}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ds", {31'd0, ds}, 0);
    chk("rst_err", {31'd0, err_timeout}, 0);
    chk("rst_dv", {31'd0, data_valid}, 0);
    chk("rst_addr", {24'd0, addr_out}, 0);
    chk("rst_data", {24'd0, data_out}, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_rd", {31'd0, rd}, 0);

    // single beat, data 0xA5 presented in the WAIT cycle (cycle 2)
    run(8'h10, 4'h0, 64'h0, 8'hA3, 4, 0, 0);
    chk("s_rd1", {31'd0, rd_log[1]}, 1);
    chk("s_rd2", {31'd0, rd_log[2]}, 1);
    chk("s_addr1", {24'd0, addr_log[1]}, 32'h10);
    chk("s_addr2", {24'd0, addr_log[2]}, 32'h10);
    chk("s_ds3", {31'd0, ds_log[3]}, 1);
    chk("s_dv3", {31'd0, dv_log[3]}, 1);
    chk("s_dout3", {24'd0, dout_log[3]}, 32'hA5);
    chk("s_rd3", {31'd0, rd_log[3]}, 0);
    chk("s_busy4", {31'd0, busy_log[4]}, 0);
    chk("s_rdcnt", rd_cnt, 2);
    chk("s_dscnt", ds_cnt, 1);

    // 4 beats from 0xFE, beat 2 sees two wait states (cycles 4,5)
    run(8'hFE, 4'h3, 64'h30, 8'h10, 12, 0, 0);
    chk("b_addr1", {24'd0, addr_log[1]}, 32'hFE);
    chk("b_addr3", {24'd0, addr_log[3]}, 32'hFF);
    chk("b_addr7", {24'd0, addr_log[7]}, 32'h00);
    chk("b_addr9", {24'd0, addr_log[9]}, 32'h01);
    chk("b_dout7", {24'd0, dout_log[7]}, 32'h16);
    chk("b_dout11", {24'd0, dout_log[11]}, 32'h1A);
    chk("b_rdcnt", rd_cnt, 10);
    chk("b_dvcnt", dv_cnt, 4);
    chk("b_dscnt", ds_cnt, 1);
    chk("b_ds11", {31'd0, ds_log[11]}, 1);
    chk("b_errcnt", err_cnt, 0);

    // ws held high: 15 WAIT cycles (2..16) then ERR in cycle 17
    run(8'h20, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 20, 0, 0);
    chk("t_rd16", {31'd0, rd_log[16]}, 1);
    chk("t_err17", {31'd0, err_log[17]}, 1);
    chk("t_rd17", {31'd0, rd_log[17]}, 0);
    chk("t_errcnt", err_cnt, 1);
    chk("t_dscnt", ds_cnt, 0);
    chk("t_dvcnt", dv_cnt, 0);
    chk("t_rdcnt", rd_cnt, 16);
    chk("t_busy18", {31'd0, busy_log[18]}, 0);

    // 14 wait states then ready in cycle 16: just under the limit
    run(8'h20, 4'h0, 64'h0000_FFFC, 8'h30, 19, 0, 0);
    chk("t14_ds17", {31'd0, ds_log[17]}, 1);
    chk("t14_dout17", {24'd0, dout_log[17]}, 32'h40);
    chk("t14_errcnt", err_cnt, 0);
    chk("t14_dvcnt", dv_cnt, 1);

    // go with a different address during beat 2 of a 3-beat burst
    run(8'h40, 4'h2, 64'h0, 8'h00, 9, 3, 0);
    chk("g_addr3", {24'd0, addr_log[3]}, 32'h41);
    chk("g_addr5", {24'd0, addr_log[5]}, 32'h42);
    chk("g_addr8", {24'd0, addr_log[8]}, 32'h42);
    chk("g_rdcnt", rd_cnt, 6);
    chk("g_dscnt", ds_cnt, 1);
    chk("g_busy8", {31'd0, busy_log[8]}, 0);

    // reset asserted during WAIT of beat 2 (cycle 4)
    run(8'h50, 4'h3, 64'h0, 8'h00, 8, 0, 4);
    chk("r_rd5", {31'd0, rd_log[5]}, 0);
    chk("r_busy5", {31'd0, busy_log[5]}, 0);
    chk("r_addr5", {24'd0, addr_log[5]}, 0);
    chk("r_dscnt", ds_cnt, 0);
    chk("r_errcnt", err_cnt, 0);
    chk("r_dvcnt", dv_cnt, 1);
    chk("r_rdcnt", rd_cnt, 4);

    run(8'hA0, 4'h1, 64'h0, 8'h60, 6, 0, 0);
    chk("r2_addr1", {24'd0, addr_log[1]}, 32'hA0);
    chk("r2_addr3", {24'd0, addr_log[3]}, 32'hA1);
    chk("r2_dout5", {24'd0, dout_log[5]}, 32'h64);
    chk("r2_dscnt", ds_cnt, 1);
    chk("r2_dvcnt", dv_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
